// File: rtl/fuzz_sig_pipe.sv
// rtl/fuzz_sig_pipe.sv - multi-lane stall-able pipeline with entry transform, MISR signature and beat counter
module fuzz_sig_pipe #(
  parameter int                 DATA_W  = 16,
  parameter int                 LANES   = 2,
  parameter int                 DEPTH   = 4,
  parameter int                 SIG_W   = 32,
  parameter logic [SIG_W-1:0]   POLY    = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]   SEED    = 32'hFFFFFFFF,
  parameter int                 COUNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [1:0]                mode,
  input  logic                      stall,
  input  logic                      sig_clear,
  output logic                      out_valid,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [SIG_W-1:0]          sig,
  output logic [COUNT_W-1:0]        count
);

  localparam int DW = LANES * DATA_W;

  logic [DW-1:0]     xf_data;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] fold;
  logic [DEPTH-1:0]  vld;
  logic [DW-1:0]     dat [DEPTH];
  logic              retire;

  always_comb begin
    xf_data = '0;
    lane    = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = in_data[i*DATA_W +: DATA_W];
      case (mode)
        2'd0:    xf_data[i*DATA_W +: DATA_W] = lane;
        2'd1:    xf_data[i*DATA_W +: DATA_W] = ~lane;
        2'd2:    xf_data[i*DATA_W +: DATA_W] = {lane[DATA_W-2:0], lane[DATA_W-1]};
        default: xf_data[i*DATA_W +: DATA_W] = lane + DATA_W'(i);
      endcase
    end
  end

  // Invalid slots shift too, so the data registers follow the valid chain exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) dat[k] <= '0;
    end else if (!stall) begin
      vld[0] <= in_valid;
      dat[0] <= xf_data;
      for (int k = 1; k < DEPTH; k++) begin
        vld[k] <= vld[k-1];
        dat[k] <= dat[k-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign retire    = out_valid && !stall;

  always_comb begin
    fold = '0;
    for (int i = 0; i < LANES; i++) fold = fold ^ out_data[i*DATA_W +: DATA_W];
  end

  // Clear wins over a same-edge retire and also acts during stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig   <= SEED;
      count <= '0;
    end else if (sig_clear) begin
      sig   <= SEED;
      count <= '0;
    end else if (retire) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(fold);
      if (count != '1) count <= count + COUNT_W'(1);
    end
  end

endmodule
